bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
Shares one 8-bit binary-to-BCD shift-add-3 converter between N_REQ requesters. It arbitrates round-robin, loads the winner's operand, and sequences the 8 shift/correct steps. It then presents the 3-digit BCD result with the requester's ID on a valid/ready response port. It sits between display/report producers and the 7-segment/BCD output path, replacing per-source converters.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, $clog2(N_REQ), width of rsp_id (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester request
req_data  input  N_REQ*8  packed operands; requester k uses bits [8k+7:8k]
req_ready  output  N_REQ  one-hot grant; handshake when req_valid[k] & req_ready[k]
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_W  index of requester that owns rsp_bcd
rsp_bcd  output  12  {hundreds, tens, units} BCD digits
busy  output  1  high whenever state != IDLE

Behaviour:
- Decided: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_bcd 0, busy 0.
  - Shift register, digit registers and step counter all 0.
  - req_ready forced to 0 while rst is high.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - If any req_valid bit is set, pick the winner k: first set bit searching from rr_ptr upward, wrapping at N_REQ-1 -> 0.
  - req_ready = one-hot(k) combinationally, this cycle only.
  - At the clock edge: shift reg <= operand k; digits <= 0; step cnt <= 0; rsp_id <= k; rr_ptr <= (k+1) mod N_REQ (wrap is correct for non-power-of-2 N_REQ); go to SHIFT.
  - If no requests, stay in IDLE; req_ready = 0.
- SHIFT (exactly 8 cycles):
  - Correction: F_u = units>=5 ? units+3 : units; same rule for tens. Hundreds needs no correction (max 2).
  - Each cycle: {hund,tens,units} <= {hund[2:0], F_t, F_u, sh[7]}; sh <= sh<<1; cnt++.
  - After the 8th step, rsp_bcd <= digits and go to DONE.
  - req_ready = 0 throughout.
- DONE:
  - rsp_valid = 1; rsp_bcd and rsp_id held stable.
  - When rsp_ready = 1, rsp_valid drops next cycle and state returns to IDLE.
  - No new grant is issued while in DONE.
- Latency: handshake in cycle 0 -> rsp_valid high from cycle 9. If rsp_ready is held high, the next grant comes in cycle 10; throughput is 1 result per 10 cycles.
- req_valid dropping before grant: no effect, no error. req_data is sampled only at the handshake edge; later changes are ignored.
- rsp_ready high outside DONE: ignored.
- Reset mid-operation (any state): conversion is aborted, no response is produced, and all reset values apply immediately (asynchronous).
- Width rule: all operands 0..255 map to BCD 0x000..0x255. Tens and units never exceed 9 after each step.

Decomposition:
- Package bcd_pkg:
  - BIN_W=8, BCD_W=12, N_STEPS=8.
  - typedef enum {IDLE, SHIFT, DONE} sched_state_t.
  - function add3_fix(4-bit digit).
- Sub-module bcd_dabble_core:
  - Contents: shift reg, digit regs, step counter.
  - Inputs: clk, rst, load, load_data[7:0], step_en.
  - Outputs: bcd[11:0], last_step.
- bcd_conv_sched holds the arbiter, FSM and response registers, and drives load/step_en.

Test Plan:
- Single requester: req_valid=4'b0001, data 8'd0 -> req_ready=0001 in cycle 0; rsp_valid at cycle 9 with rsp_bcd=12'h000, rsp_id=0.
- Boundary values on requester 2:
  - 8'd255 -> 12'h255, rsp_id=2.
  - 8'd199 -> 12'h199.
  - 8'd100 -> 12'h100.
  - 8'd9 -> 12'h009.
- Fairness: all 4 requesters hold req_valid with data 10,20,30,40 -> grant order 0,1,2,3,0. Responses are 12'h010, 020, 030, 040 with matching IDs, and grants are 10 cycles apart.
- Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_bcd and rsp_id stable; req_ready stays 0; the next grant comes one cycle after the rsp_ready handshake.
- Reset: rst pulsed during SHIFT step 4 -> rsp_valid=0, busy=0 and req_ready=0 immediately. After release, req_valid=4'b1000 is granted (rr_ptr=0 search) and converts correctly.
- Exhaustive sweep: operands 0..255 on requester 1 with rsp_ready=1 -> each rsp_bcd equals the decimal digits of the operand.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the shared binary-to-BCD conversion scheduler.
//   BIN_W/BCD_W : operand and result widths
//   N_STEPS     : shift/correct steps per conversion (one per operand bit)
//   sched_state_t : scheduler FSM states
//   add3_fix    : shift-add-3 digit correction (add 3 when digit >= 5)
package bcd_pkg;

    localparam int unsigned BIN_W   = 8;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned N_STEPS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic logic [3:0] add3_fix(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Shift-add-3 (double dabble) datapath for one 8-bit operand.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : load load_data_i, clear digits and step counter
//   load_data_i    : binary operand
//   step_en_i      : perform one correct-then-shift step
//   bcd_o          : digit value produced by the current step (valid while stepping)
//   last_step_o    : the current step is the final one
module bcd_dabble_core
    import bcd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [BIN_W-1:0] load_data_i,
    input  logic             step_en_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             last_step_o
);

    logic [BIN_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0] dig_q, dig_d;
    logic [BCD_W-1:0] corrected;
    logic [BCD_W-1:0] dig_step;
    logic [3:0]       cnt_q, cnt_d;

    // Hundreds never exceeds 2 mid-conversion, so it needs no correction.
    assign corrected = {dig_q[11:8], add3_fix(dig_q[7:4]), add3_fix(dig_q[3:0])};
    assign dig_step  = (corrected << 1) | BCD_W'(sh_q[BIN_W-1]);

    // The scheduler captures the result on the last step edge, so expose the
    // step result rather than the registered digits.
    assign bcd_o       = dig_step;
    assign last_step_o = (cnt_q == 4'(N_STEPS - 1));

    always_comb begin
        sh_d  = sh_q;
        dig_d = dig_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = load_data_i;
            dig_d = '0;
            cnt_d = '0;
        end else if (step_en_i) begin
            sh_d  = sh_q << 1;
            dig_d = dig_step;
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q  <= '0;
            dig_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            dig_q <= dig_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter between N_REQ requesters.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester request; req_data[8k+7:8k] is requester k's operand
//   req_ready  : one-hot grant, asserted only in IDLE for the round-robin winner
//   rsp_valid  : result available (DONE); rsp_ready accepts it
//   rsp_id     : requester owning rsp_bcd
//   rsp_bcd    : {hundreds, tens, units}
//   busy       : scheduler not idle
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*BIN_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [BCD_W-1:0]       rsp_bcd,
    output logic                   busy
);

    sched_state_t     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [BCD_W-1:0] rsp_bcd_q, rsp_bcd_d;

    logic             req_any;
    logic [ID_W-1:0]  win_idx;
    logic [BIN_W-1:0] win_data;
    logic [N_REQ-1:0] grant;
    logic             core_load;
    logic             core_step;
    logic [BCD_W-1:0] core_bcd;
    logic             core_last;

    // First asserted request at or above rr_ptr, wrapping at N_REQ-1.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        req_any = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_REQ;
            if (!req_any && |(req_valid & (N_REQ'(1) << idx))) begin
                req_any = 1'b1;
                win_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == win_idx) begin
                win_data = req_data[k*BIN_W +: BIN_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_id_d  = rsp_id_q;
        rsp_bcd_d = rsp_bcd_q;
        grant     = '0;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant     = N_REQ'(1) << win_idx;
                    core_load = 1'b1;
                    rsp_id_d  = win_idx;
                    // Modulo keeps the wrap correct for non-power-of-2 N_REQ.
                    rr_ptr_d  = ID_W'((32'(win_idx) + 32'd1) % N_REQ);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                core_step = 1'b1;
                if (core_last) begin
                    rsp_bcd_d = core_bcd;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            rsp_id_q  <= '0;
            rsp_bcd_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_bcd_q <= rsp_bcd_d;
        end
    end

    bcd_dabble_core u_core (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (core_load),
        .load_data_i (win_data),
        .step_en_i   (core_step),
        .bcd_o       (core_bcd),
        .last_step_o (core_last)
    );

    // Grant must stay low during reset even though req_valid may be asserted.
    assign req_ready = rst ? '0 : grant;
    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = rsp_id_q;
    assign rsp_bcd   = rsp_bcd_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for bcd_conv_sched (N_REQ = 4).
module tb_bcd_conv_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_bcd;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_conv_sched #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bcd   (rsp_bcd),
        .busy      (busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request from requester k and wait for its response (rsp_ready assumed 1).
    // gnt0: req_ready in the request cycle; lat: cycles until rsp_valid (-1 on timeout).
    task automatic do_req(input int k, input logic [7:0] d, output logic [3:0] gnt0,
                          output int lat, output logic [11:0] bcd, output logic [1:0] id);
        @(negedge clk);
        req_data[k*8 +: 8] = d;
        req_valid = 4'(1 << k);
        #1 gnt0 = req_ready;
        @(posedge clk);
        #1 req_valid = 4'b0000;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        bcd = rsp_bcd;
        id  = rsp_id;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_data = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        tests++; if (rsp_bcd !== 12'h000) begin fails++; $display("FAIL reset_rsp_bcd got %h want 000", rsp_bcd); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] g; int lat; logic [11:0] b; logic [1:0] id;
        do_req(0, 8'd0, g, lat, b, id);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL single_grant got %b want 0001", g); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL single_latency got %0d want 9", lat); end
        tests++; if (b !== 12'h000) begin fails++; $display("FAIL single_bcd got %h want 000", b); end
        tests++; if (id !== 2'd0) begin fails++; $display("FAIL single_id got %0d want 0", id); end
    endtask

    task automatic test_boundary();
        logic [7:0]  ops [4] = '{8'd255, 8'd199, 8'd100, 8'd9};
        logic [11:0] exp [4] = '{12'h255, 12'h199, 12'h100, 12'h009};
        logic [3:0] g; int lat; logic [11:0] b; logic [1:0] id;
        for (int i = 0; i < 4; i++) begin
            do_req(2, ops[i], g, lat, b, id);
            tests++;
            if (g !== 4'b0100 || lat !== 9 || b !== exp[i] || id !== 2'd2) begin
                fails++;
                $display("FAIL boundary_%0d got grant=%b lat=%0d bcd=%h id=%0d want 0100/9/%h/2",
                         ops[i], g, lat, b, id, exp[i]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  g_val [5];
        int          g_cyc [5];
        logic [1:0]  r_id [4];
        logic [11:0] r_bcd [4];
        logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [11:0] exp_b [4] = '{12'h010, 12'h020, 12'h030, 12'h040};
        int ng = 0;
        int nr = 0;
        for (int i = 0; i < 5; i++) begin g_val[i] = '0; g_cyc[i] = -1; end
        for (int i = 0; i < 4; i++) begin r_id[i] = '0; r_bcd[i] = '0; end
        // Restart with rr_ptr = 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        rsp_ready = 1'b1;
        req_data = {8'd40, 8'd30, 8'd20, 8'd10};
        req_valid = 4'hF;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (req_ready !== 4'b0000 && ng < 5) begin
                g_val[ng] = req_ready; g_cyc[ng] = c; ng++;
            end
            if (rsp_valid === 1'b1 && nr < 4) begin
                r_id[nr] = rsp_id; r_bcd[nr] = rsp_bcd; nr++;
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        tests++; if (ng !== 5) begin fails++; $display("FAIL fair_grant_count got %0d want 5", ng); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (g_val[i] !== exp_g[i] || g_cyc[i] !== 10 * i) begin
                fails++;
                $display("FAIL fair_grant_%0d got %b@%0d want %b@%0d", i, g_val[i], g_cyc[i],
                         exp_g[i], 10 * i);
            end
        end
        tests++; if (nr !== 4) begin fails++; $display("FAIL fair_rsp_count got %0d want 4", nr); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (r_id[i] !== 2'(i) || r_bcd[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL fair_rsp_%0d got id=%0d bcd=%h want id=%0d bcd=%h", i, r_id[i],
                         r_bcd[i], i, exp_b[i]);
            end
        end
        for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat = -1;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_data[15:8] = 8'd42;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_data[23:16] = 8'd77;
        req_valid = 4'b0100;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = c; break; end
        end
        tests++; if (lat !== 9) begin fails++; $display("FAIL bp_latency got %0d want 9", lat); end
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_bcd !== 12'h042 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_hold_%0d got valid=%b bcd=%h id=%0d ready=%b want 1/042/1/0000",
                         i, rsp_valid, rsp_bcd, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL bp_release got valid=%b ready=%b want 0/0100", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 4'b0000;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = c; break; end
        end
        tests++;
        if (lat !== 9 || rsp_bcd !== 12'h077 || rsp_id !== 2'd2) begin
            fails++;
            $display("FAIL bp_next got lat=%0d bcd=%h id=%0d want 9/077/2", lat, rsp_bcd, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat = -1;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_data[7:0] = 8'd123;
        req_valid = 4'b0001;
        @(posedge clk);
        #1 req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        req_data[31:24] = 8'd200;
        req_valid = 4'b1000;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid got valid=%b busy=%b ready=%b want 0/0/0000", rsp_valid, busy,
                     req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rst_regrant got %b want 1000", req_ready); end
        @(posedge clk);
        #1 req_valid = 4'b0000;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = c; break; end
        end
        tests++;
        if (lat !== 9 || rsp_bcd !== 12'h200 || rsp_id !== 2'd3) begin
            fails++;
            $display("FAIL rst_after got lat=%0d bcd=%h id=%0d want 9/200/3", lat, rsp_bcd, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [3:0] g; int lat; logic [11:0] b; logic [1:0] id;
        logic [11:0] exp;
        rsp_ready = 1'b1;
        for (int d = 0; d < 256; d++) begin
            exp = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            do_req(1, 8'(d), g, lat, b, id);
            tests++;
            if (lat !== 9 || b !== exp || id !== 2'd1) begin
                fails++;
                $display("FAIL sweep_%0d got lat=%0d bcd=%h id=%0d want 9/%h/1", d, lat, b, id, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
